// File: rtl/somador_pkg.sv
// rtl/somador_pkg.sv - shared width, operand type and result record for the registered adder
package somador_pkg;

    localparam int SOMADOR_WIDTH = 4;

    typedef logic [SOMADOR_WIDTH-1:0] nibble_t;

    // One registered result: sum plus the three status flags.
    typedef struct packed {
        nibble_t s;
        logic    cout;
        logic    ovf;
        logic    zero;
    } somador_res_t;

endpackage

// File: rtl/somador_1bit.sv
// rtl/somador_1bit.sv - one-bit full adder, the ripple-chain stage
//
// Ports:
//   x, y : operand bits
//   ci   : carry in from the previous stage
//   sum  : x ^ y ^ ci
//   co   : carry out to the next stage
module somador_1bit (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic sum,
    output logic co
);

    logic p;

    assign p   = x ^ y;
    assign sum = p ^ ci;
    assign co  = (x & y) | (ci & p);

endmodule

// File: rtl/somador_4bit.sv
// rtl/somador_4bit.sv - registered ripple-carry adder with carry, overflow and zero flags
//
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   in_valid  : a/b/cin are sampled on this edge
//   a, b      : WIDTH-bit operands
//   cin       : carry in
//   out_valid : one-cycle pulse per accepted operand set
//   s         : registered (a+b+cin) mod 2^WIDTH
//   cout      : registered carry out
//   ovf       : registered two's-complement overflow
//   zero      : registered s==0 flag
module somador_4bit
    import somador_pkg::*;
#(
    parameter int WIDTH = SOMADOR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;
    logic             ovf_next;
    logic             zero_next;

    assign carry[0] = cin;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_chain
            somador_1bit u_fa (
                .x   (a[i]),
                .y   (b[i]),
                .ci  (carry[i]),
                .sum (sum[i]),
                .co  (carry[i+1])
            );
        end
    endgenerate

    // Overflow only when both operands share a sign and the sum's sign differs;
    // it is independent of the unsigned carry out.
    assign ovf_next  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign zero_next = (sum == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

    // The shared result record is fixed at the signed-off width; other widths
    // keep the same fields as plain registers.
    generate
        if (WIDTH == SOMADOR_WIDTH) begin : g_pkg_res
            somador_res_t res_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    res_q <= '0;
                end else if (in_valid) begin
                    res_q <= '{s: sum, cout: carry[WIDTH], ovf: ovf_next, zero: zero_next};
                end
            end

            assign s    = res_q.s;
            assign cout = res_q.cout;
            assign ovf  = res_q.ovf;
            assign zero = res_q.zero;
        end else begin : g_gen_res
            logic [WIDTH-1:0] s_q;
            logic             cout_q;
            logic             ovf_q;
            logic             zero_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s_q    <= '0;
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (in_valid) begin
                    s_q    <= sum;
                    cout_q <= carry[WIDTH];
                    ovf_q  <= ovf_next;
                    zero_q <= zero_next;
                end
            end

            assign s    = s_q;
            assign cout = cout_q;
            assign ovf  = ovf_q;
            assign zero = zero_q;
        end
    endgenerate

endmodule

// File: tb/tb_somador_4bit.sv
// tb/tb_somador_4bit.sv - self-checking bench for somador_4bit
module tb_somador_4bit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] a = 4'd0;
    logic [3:0] b = 4'd0;
    logic       cin = 1'b0;
    logic       out_valid;
    logic [3:0] s;
    logic       cout;
    logic       ovf;
    logic       zero;

    int n_checks = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    somador_4bit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the sampled operands.
    logic       m_valid = 1'b0;
    logic [3:0] m_s = 4'd0;
    logic       m_cout = 1'b0;
    logic       m_ovf = 1'b0;
    logic       m_zero = 1'b0;

    always @(posedge clk or posedge rst) begin
        int u;
        int sg;
        if (rst) begin
            m_valid = 1'b0;
            m_s     = 4'd0;
            m_cout  = 1'b0;
            m_ovf   = 1'b0;
            m_zero  = 1'b0;
        end else begin
            m_valid = in_valid;
            if (in_valid) begin
                u      = int'(a) + int'(b) + int'(cin);
                m_s    = 4'(u % 16);
                m_cout = (u >= 16);
                sg     = (a >= 4'd8 ? int'(a) - 16 : int'(a))
                       + (b >= 4'd8 ? int'(b) - 16 : int'(b)) + int'(cin);
                m_ovf  = (sg > 7) || (sg < -8);
                m_zero = (m_s == 4'd0);
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            cmp("model_valid", 32'(out_valid), 32'(m_valid));
            cmp("model_s",     32'(s),         32'(m_s));
            cmp("model_cout",  32'(cout),      32'(m_cout));
            cmp("model_ovf",   32'(ovf),       32'(m_ovf));
            cmp("model_zero",  32'(zero),      32'(m_zero));
        end
    end

    task automatic vec(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                       input logic [3:0] es, input logic ec, input logic eo, input logic ez);
        in_valid = 1'b1;
        a = va;
        b = vb;
        cin = vc;
        @(posedge clk);
        #1;
        cmp("lit_valid", 32'(out_valid), 32'd1);
        cmp("lit_s",     32'(s),         32'(es));
        cmp("lit_cout",  32'(cout),      32'(ec));
        cmp("lit_ovf",   32'(ovf),       32'(eo));
        cmp("lit_zero",  32'(zero),      32'(ez));
    endtask

    task automatic check_all_zero(input string name);
        cmp(name, {27'd0, out_valid, s}, 32'd0);
        cmp(name, {29'd0, cout, ovf, zero}, 32'd0);
    endtask

    logic [3:0] hs_a [3] = '{4'd1, 4'd4, 4'd6};
    logic [3:0] hs_b [3] = '{4'd2, 4'd4, 4'd3};
    logic       hs_c [3] = '{1'b0, 1'b0, 1'b1};

    initial begin
        int cnt;
        #1 check_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        rst = 1'b0;

        // Directed sums with hand-computed results.
        vec(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        vec(4'b0011, 4'b0101, 1'b1, 4'b1001, 1'b0, 1'b1, 1'b0);
        vec(4'b0010, 4'b0001, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b0);
        vec(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1);
        vec(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
        vec(4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0);
        vec(4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1);

        // Handshake: three accepted sets, then idle with changing operands.
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 3) begin
                in_valid = 1'b1;
                a = hs_a[i];
                b = hs_b[i];
                cin = hs_c[i];
            end else begin
                in_valid = 1'b0;
                a = 4'($urandom);
                b = 4'($urandom);
                cin = 1'($urandom);
            end
            @(posedge clk);
            #1;
            if (out_valid) cnt++;
        end
        cmp("hs_valid_cycles", 32'(cnt), 32'd3);
        cmp("hs_s_held", 32'(s), 32'd10);
        cmp("hs_cout_held", 32'(cout), 32'd0);

        // Asynchronous reset mid-cycle while a result is valid.
        in_valid = 1'b1;
        a = 4'd9;
        b = 4'd3;
        cin = 1'b0;
        @(posedge clk);
        #1;
        cmp("pre_rst_valid", 32'(out_valid), 32'd1);
        cmp("pre_rst_s", 32'(s), 32'd12);
        a = 4'd5;
        b = 4'd0;
        #1 rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        #8;
        check_all_zero("rst_hold");
        #3 rst = 1'b0;
        #1;
        check_all_zero("rst_released");
        @(posedge clk);
        #1;
        cmp("post_rst_valid", 32'(out_valid), 32'd1);
        cmp("post_rst_s", 32'(s), 32'd5);

        // Randomized traffic with gaps.
        for (int i = 0; i < 300; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            a = 4'($urandom);
            b = 4'($urandom);
            cin = 1'($urandom);
            @(posedge clk);
            #1;
        end

        // Exhaustive stream of all operand combinations.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            in_valid = 1'b1;
            a = v[8:5];
            b = v[4:1];
            cin = v[0];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cmp("final_idle", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
